csa_pipe_adder: RTL and testbench

//   Pipelined carry-select adder. It sits downstream of MUX_4bit: each stage precomputes both

---
 rtl/csa_pkg.sv | 29 ++
 rtl/csa_block.sv | 28 ++
 rtl/csa_pipe_adder.sv | 134 +++++++++++++
 tb/tb_csa_pipe_adder.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/csa_pkg.sv
// Shared constants, stage-record layout and block-index helpers for the pipelined carry-select adder.
package csa_pkg;

  localparam int CSA_WIDTH = 16;
  localparam int CSA_BLK   = 4;

  // Logical content of one pipeline stage; the top stores it in a triangular layout
  // so each stage keeps only the operand bits still to be added.
  typedef struct packed {
    logic                 valid;
    logic                 carry;
    logic [CSA_WIDTH-1:0] psum;
    logic [CSA_WIDTH-1:0] ra;
    logic [CSA_WIDTH-1:0] rb;
  } csa_stage_t;

  function automatic int blk_cnt(input int width, input int blk);
    return width / blk;
  endfunction

  function automatic int blk_lo(input int k, input int blk);
    return k * blk;
  endfunction

  function automatic int rem_w(input int width, input int blk, input int k);
    return width - blk * (k + 1);
  endfunction

endpackage

// File: rtl/csa_block.sv
// One carry-select block: both block sums are precomputed and a 4-bit style mux picks one by sel.
module csa_block
  import csa_pkg::*;
#(
  parameter int BLK = CSA_BLK
) (
  input  logic [BLK-1:0] a,
  input  logic [BLK-1:0] b,
  input  logic           sel,
  output logic [BLK-1:0] s,
  output logic           co
);

  logic [BLK:0] r0, r1;

  assign r0 = {1'b0, a} + {1'b0, b};
  assign r1 = {1'b0, a} + {1'b0, b} + (BLK+1)'(1);

  always_comb begin
    s  = r0[BLK-1:0];
    co = r0[BLK];
    if (sel) begin
      s  = r1[BLK-1:0];
      co = r1[BLK];
    end
  end

endmodule

// File: rtl/csa_pipe_adder.sv
// Pipelined carry-select adder, one BLK-wide block per stage, valid/ready on both sides.
// Optional CSA_OVF_EN adds a registered signed-overflow output aligned with sum.
module csa_pipe_adder
  import csa_pkg::*;
#(
  parameter int WIDTH = CSA_WIDTH,
  parameter int BLK   = CSA_BLK
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef CSA_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int NBLK = blk_cnt(WIDTH, BLK);

  logic            adv;
  logic [NBLK-1:0] vld_pipe;
  logic [NBLK-1:0] cy_pipe;

  // Whole pipe moves as one; stalls only when the output holds unconsumed data.
  assign adv       = !vld_pipe[NBLK-1] | out_ready;
  assign in_ready  = adv;
  assign out_valid = vld_pipe[NBLK-1];
  assign cout      = cy_pipe[NBLK-1];

  for (genvar k = 0; k < NBLK; k++) begin : stg
    localparam int PW = blk_lo(k + 1, BLK);

    logic [BLK-1:0] ba, bb, bs;
    logic           sel, bco;
    logic           vld_q, cy_q;
    logic [PW-1:0]  psum_q;

    csa_block #(.BLK(BLK)) u_blk (
      .a   (ba),
      .b   (bb),
      .sel (sel),
      .s   (bs),
      .co  (bco)
    );

    assign vld_pipe[k] = vld_q;
    assign cy_pipe[k]  = cy_q;

    if (k == 0) begin : g_head
      assign ba  = a[BLK-1:0];
      assign bb  = b[BLK-1:0];
      assign sel = cin;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          vld_q  <= 1'b0;
          cy_q   <= 1'b0;
          psum_q <= '0;
        end else if (adv) begin
          vld_q  <= in_valid;
          cy_q   <= bco;
          psum_q <= bs;
        end
      end
    end else begin : g_body
      assign ba  = stg[k-1].g_rem.ra_q[BLK-1:0];
      assign bb  = stg[k-1].g_rem.rb_q[BLK-1:0];
      assign sel = cy_pipe[k-1];

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          vld_q  <= 1'b0;
          cy_q   <= 1'b0;
          psum_q <= '0;
        end else if (adv) begin
          vld_q  <= vld_pipe[k-1];
          cy_q   <= bco;
          psum_q <= {bs, stg[k-1].psum_q};
        end
      end
    end

    // Operand bits not yet consumed, right-aligned so the next block is always at [BLK-1:0].
    if (k < NBLK - 1) begin : g_rem
      localparam int RW = rem_w(WIDTH, BLK, k);

      logic [RW-1:0] ra_q, rb_q, ra_nx, rb_nx;

      if (k == 0) begin : g_src
        assign ra_nx = a[WIDTH-1:BLK];
        assign rb_nx = b[WIDTH-1:BLK];
      end else begin : g_src
        assign ra_nx = stg[k-1].g_rem.ra_q[RW+BLK-1:BLK];
        assign rb_nx = stg[k-1].g_rem.rb_q[RW+BLK-1:BLK];
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          ra_q <= '0;
          rb_q <= '0;
        end else if (adv) begin
          ra_q <= ra_nx;
          rb_q <= rb_nx;
        end
      end
    end
  end

  assign sum = stg[NBLK-1].psum_q;

`ifdef CSA_OVF_EN
  logic ovf_q, ovf_nx;

  // Carry into the MSB is recovered as a^b^s at that bit, then compared with carry out.
  assign ovf_nx = stg[NBLK-1].ba[BLK-1] ^ stg[NBLK-1].bb[BLK-1]
                ^ stg[NBLK-1].bs[BLK-1] ^ stg[NBLK-1].bco;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)      ovf_q <= 1'b0;
    else if (adv) ovf_q <= ovf_nx;
  end

  assign ovf = ovf_q;
`endif

endmodule

// File: tb/tb_csa_pipe_adder.sv
// Randomized and directed bench for csa_pipe_adder with a queue-based arithmetic scoreboard.
module tb_csa_pipe_adder;

  localparam int W    = 16;
  localparam int NBLK = 4;

  typedef struct {
    logic [W-1:0] s;
    logic         c;
    logic         v;
  } exp_t;

  logic         clk, rst, in_valid, in_ready, cin, out_valid, out_ready, cout;
  logic [W-1:0] a, b, sum;
`ifdef CSA_OVF_EN
  logic         ovf;
`endif

  int   n_chk  = 0;
  int   n_pass = 0;
  exp_t q[$];

  csa_pipe_adder dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout)
`ifdef CSA_OVF_EN
    ,
    .ovf       (ovf)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
    exp_t        e;
    logic [W:0]  t;
    t   = {1'b0, x} + {1'b0, y} + (W+1)'(c);
    e.s = t[W-1:0];
    e.c = t[W];
    e.v = (x[W-1] == y[W-1]) && (t[W-1] != x[W-1]);
    return e;
  endfunction

  // Scoreboard: handshakes are evaluated mid-cycle, when inputs and ready are settled.
  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid && out_ready) begin
        if (q.size() == 0) chk("spurious_out", 32'(out_valid), 32'd0);
        else begin
          chk("sb_sum", 32'(sum), 32'(q[0].s));
          chk("sb_cout", 32'(cout), 32'(q[0].c));
`ifdef CSA_OVF_EN
          chk("sb_ovf", 32'(ovf), 32'(q[0].v));
`endif
          void'(q.pop_front());
        end
      end
      if (in_valid && in_ready) q.push_back(model(a, b, cin));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
    int   n;
    logic acc;
    n = 0;
    a = x; b = y; cin = c; in_valid = 1'b1;
    do begin
      acc = in_ready;
      step();
      n++;
    end while (!acc && n < 50);
    if (!acc) chk("send_timeout", 32'd0, 32'd1);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    out_ready = 1'b1;
    in_valid  = 1'b0;
    while ((q.size() != 0 || out_valid) && n < 40) begin
      step();
      n++;
    end
    chk("drain_empty", 32'(q.size()), 32'd0);
    chk("drain_idle", 32'(out_valid), 32'd0);
  endtask

  logic [W-1:0] ea[4], eb[4], es[4];
  logic         ec[4], eo[4];
  exp_t         e0;

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0; cin = 1'b0;
    #2;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_sum", 32'(sum), 32'd0);
    chk("rst_cout", 32'(cout), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    step();
    rst = 1'b0;
    step();

    // Wrap-around and latency
    send(16'hFFFF, 16'h0001, 1'b0);
    chk("lat_e0", 32'(out_valid), 32'd0);
    step(); chk("lat_e1", 32'(out_valid), 32'd0);
    step(); chk("lat_e2", 32'(out_valid), 32'd0);
    step();
    chk("lat_e3", 32'(out_valid), 32'd1);
    chk("wrap_sum", 32'(sum), 32'h0000);
    chk("wrap_cout", 32'(cout), 32'd1);
    drain();

    // Back-to-back, results on consecutive cycles
    ea = '{16'h1234, 16'h0F0F, 16'h8000, 16'h00FF};
    eb = '{16'h1111, 16'h00F1, 16'h8000, 16'h0001};
    ec = '{1'b0, 1'b0, 1'b1, 1'b0};
    es = '{16'h2345, 16'h1000, 16'h0001, 16'h0100};
    eo = '{1'b0, 1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 4; i++) send(ea[i], eb[i], ec[i]);
    for (int i = 0; i < 4; i++) begin
      chk("b2b_valid", 32'(out_valid), 32'd1);
      chk("b2b_sum", 32'(sum), 32'(es[i]));
      chk("b2b_cout", 32'(cout), 32'(eo[i]));
      step();
    end
    drain();

    // Backpressure on a full pipe
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) send(ea[i] ^ 16'h5A5A, eb[i], ec[i]);
    e0 = model(ea[0] ^ 16'h5A5A, eb[0], ec[0]);
    a = 16'h4321; b = 16'h1234; cin = 1'b1; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk("stall_valid", 32'(out_valid), 32'd1);
      chk("stall_in_ready", 32'(in_ready), 32'd0);
      chk("stall_sum", 32'(sum), 32'(e0.s));
      chk("stall_cout", 32'(cout), 32'(e0.c));
      step();
    end
    out_ready = 1'b1;
    send(16'h4321, 16'h1234, 1'b1);
    drain();

    // Reset while the output holds valid data: clears before any edge
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) send(16'h0100 * 16'(i + 1), 16'h0011, 1'b1);
    chk("pre_rst_valid", 32'(out_valid), 32'd1);
    rst = 1'b1;
    #1;
    chk("async_rst_valid", 32'(out_valid), 32'd0);
    chk("async_rst_sum", 32'(sum), 32'd0);
    chk("async_rst_cout", 32'(cout), 32'd0);
    q.delete();
    #1 rst = 1'b0;
    out_ready = 1'b1;
    step();

    // Two transactions in flight are dropped by a reset pulse
    send(16'hAAAA, 16'h1111, 1'b0);
    send(16'h0001, 16'h0002, 1'b1);
    rst = 1'b1;
    #2 rst = 1'b0;
    q.delete();
    for (int i = 0; i < 6; i++) begin
      chk("flushed_no_valid", 32'(out_valid), 32'd0);
      step();
    end

`ifdef CSA_OVF_EN
    send(16'h7FFF, 16'h0001, 1'b0);
    send(16'hFFFF, 16'h0001, 1'b0);
    step(); step();
    chk("ovf_pos_sum", 32'(sum), 32'h8000);
    chk("ovf_pos", 32'(ovf), 32'd1);
    step();
    chk("ovf_neg_cout", 32'(cout), 32'd1);
    chk("ovf_neg", 32'(ovf), 32'd0);
    drain();
`endif

    // Random traffic with random bubbles and backpressure
    for (int i = 0; i < 400; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      a         = W'($urandom);
      b         = W'($urandom);
      cin       = 1'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      step();
    end
    drain();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
